// File: rtl/uart_rx_buffered_pkg.sv
// Shared UART definitions: deframer state encoding and baud timing helpers.
package uart_rx_buffered_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    // Clock cycles per serial symbol.
    function automatic int unsigned symbol_edge_time(input int unsigned clock_freq,
                                                     input int unsigned baud_rate);
        return clock_freq / baud_rate;
    endfunction

    // Offset from a symbol edge to its mid-bit sample point.
    function automatic int unsigned sample_time(input int unsigned clock_freq,
                                                input int unsigned baud_rate);
        return symbol_edge_time(clock_freq, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_buffered_sync_fifo.sv
// First-word-fall-through synchronous FIFO. Power-of-two depth, so the
// pointers wrap naturally.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop while empty is ignored; a push while full needs a same-cycle pop.
    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && ((count != FULL_COUNT) || do_pop);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver: input synchronizer, deframer FSM and byte FIFO.
module uart_rx_buffered
    import uart_rx_buffered_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 50_000_000,
    parameter int unsigned BAUD_RATE  = 1_000_000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          serial_in,
    output logic [7:0]                    data_out,
    output logic                          data_out_valid,
    input  logic                          data_out_ready,
    output logic                          frame_error,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int unsigned SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned SAMPLE_TIME      = sample_time(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned CW               = $clog2(SYMBOL_EDGE_TIME);
    localparam logic [CW-1:0] SAMPLE_LAST    = CW'(SAMPLE_TIME - 1);
    localparam logic [CW-1:0] SYMBOL_LAST    = CW'(SYMBOL_EDGE_TIME - 1);

    logic [1:0]    sync;
    logic          rx;
    uart_state_t   state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          frame_error_n;
    logic          overflow_n;
    logic          fifo_push;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop_now;

    assign rx      = sync[1];
    assign pop_now = data_out_valid && data_out_ready;

    // Deframer state, counters and one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync        <= '1;
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            frame_error <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            sync        <= {sync[0], serial_in};
            state       <= state_n;
            cnt         <= cnt_n;
            bit_idx     <= bit_idx_n;
            shreg       <= shreg_n;
            frame_error <= frame_error_n;
            overflow    <= overflow_n;
        end
    end

    // Next-state logic; the stop bit is judged mid-bit so a following start
    // bit is caught without a gap. A same-cycle pop frees space for the push.
    always_comb begin
        state_n       = state;
        cnt_n         = cnt + CW'(1);
        bit_idx_n     = bit_idx;
        shreg_n       = shreg;
        fifo_push     = 1'b0;
        frame_error_n = 1'b0;
        overflow_n    = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx) state_n = START;
            end
            START: begin
                if (cnt == SAMPLE_LAST) begin
                    cnt_n = '0;
                    if (rx) begin
                        state_n = IDLE;
                    end else begin
                        bit_idx_n = '0;
                        state_n   = DATA;
                    end
                end
            end
            DATA: begin
                if (cnt == SYMBOL_LAST) begin
                    cnt_n     = '0;
                    shreg_n   = {rx, shreg[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                if (cnt == SYMBOL_LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    if (!rx)                        frame_error_n = 1'b1;
                    else if (fifo_full && !pop_now) overflow_n    = 1'b1;
                    else                            fifo_push     = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (shreg_n),
        .pop       (data_out_ready),
        .pop_data  (data_out),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count)
    );

    assign data_out_valid = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Scoreboard bench for uart_rx_buffered at 50 MHz / 1 Mbaud.
module tb_uart_rx_buffered;

    localparam int BIT_CYC = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic       serial_in;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic       frame_error;
    logic       overflow;
    logic [3:0] count;

    int         n_pass  = 0;
    int         n_total = 0;
    logic [7:0] sb[$];
    int         fe_seen = 0;
    int         ov_seen = 0;
    logic       fe_prev = 1'b0;
    logic       ov_prev = 1'b0;
    bit         abort_tx = 1'b0;

    uart_rx_buffered #(
        .CLOCK_FREQ (50_000_000),
        .BAUD_RATE  (1_000_000),
        .FIFO_DEPTH (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .serial_in      (serial_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .frame_error    (frame_error),
        .overflow       (overflow),
        .count          (count)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Drive one frame; caller starts just after a posedge. Stops early on abort.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < BIT_CYC; c++) begin
                if (abort_tx) begin
                    serial_in = 1'b1;
                    return;
                end
                serial_in = frame[i];
                @(posedge clk);
                #1;
            end
        end
    endtask

    // Pop everything with ready high; bounded wait.
    task automatic drain(input string name);
        data_out_ready = 1'b1;
        for (int i = 0; i < 40 && data_out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check({name, "_valid"}, 32'(data_out_valid), 32'd0);
        check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    // Monitor: compares each popped head against the scoreboard and counts pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (data_out_valid && data_out_ready) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL pop_unexpected: got %02h expected no data", data_out);
                end else begin
                    check("pop_data", 32'(data_out), 32'(sb.pop_front()));
                end
            end
            if (frame_error) fe_seen++;
            if (overflow) ov_seen++;
            if (frame_error && fe_prev) begin
                n_total++;
                $display("FAIL fe_width: got 2+ cycles expected 1");
            end
            if (overflow && ov_prev) begin
                n_total++;
                $display("FAIL ov_width: got 2+ cycles expected 1");
            end
        end
        fe_prev = frame_error;
        ov_prev = overflow;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        serial_in = 1'b1;
        data_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(data_out_valid), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_fe", 32'(frame_error), 32'd0);
        check("rst_ov", 32'(overflow), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Single byte with exact push/pop timing.
        data_out_ready = 1'b1;
        sb.push_back(8'h61);
        fork
            send_byte(8'h61, 1'b1);
            begin
                repeat (477) @(posedge clk);
                @(negedge clk);
                check("single_pre_valid", 32'(data_out_valid), 32'd0);
                @(negedge clk);
                check("single_valid", 32'(data_out_valid), 32'd1);
                check("single_data", 32'(data_out), 32'h61);
                @(negedge clk);
                check("single_post_valid", 32'(data_out_valid), 32'd0);
                check("single_post_count", 32'(count), 32'd0);
            end
        join

        // Burst of 10 with consumer stalled: 8 kept, 2 overflow.
        data_out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) sb.push_back(8'h61 + 8'(i));
            send_byte(8'h61 + 8'(i), 1'b1);
        end
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("burst_count", 32'(count), 32'd8);
        check("burst_ov", 32'(ov_seen), 32'd2);
        @(posedge clk);
        #1;
        drain("burst_drain");
        @(posedge clk);
        #1;

        // Glitch shorter than half a bit.
        serial_in = 1'b0;
        repeat (10) @(posedge clk);
        #1 serial_in = 1'b1;
        repeat (60) @(posedge clk);
        @(negedge clk);
        check("glitch_count", 32'(count), 32'd0);
        check("glitch_fe", 32'(fe_seen), 32'd0);
        @(posedge clk);
        #1;

        // Framing error, then a good byte.
        send_byte(8'h55, 1'b0);
        serial_in = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("fe_count", 32'(fe_seen), 32'd1);
        check("fe_fifo_count", 32'(count), 32'd0);
        @(posedge clk);
        #1;
        sb.push_back(8'h62);
        send_byte(8'h62, 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("after_fe_rx", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;

        // Reset during data bit 4 with two bytes buffered.
        data_out_ready = 1'b0;
        sb.push_back(8'h11);
        sb.push_back(8'h22);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        check("prereset_count", 32'(count), 32'd2);
        fork
            send_byte(8'hA5, 1'b1);
            begin
                repeat (270) @(posedge clk);
                #1;
                abort_tx = 1'b1;
                rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
                sb.delete();
                @(negedge clk);
                check("midrst_count", 32'(count), 32'd0);
                check("midrst_valid", 32'(data_out_valid), 32'd0);
            end
        join
        abort_tx = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        data_out_ready = 1'b1;
        sb.push_back(8'h3C);
        send_byte(8'h3C, 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("after_rst_rx", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;

        // Full FIFO with a pop landing on the 9th byte's stop-sample edge.
        data_out_ready = 1'b0;
        for (int i = 0; i < 9; i++) sb.push_back(8'h30 + 8'(i));
        for (int i = 0; i < 8; i++) send_byte(8'h30 + 8'(i), 1'b1);
        fork
            send_byte(8'h38, 1'b1);
            begin
                repeat (477) @(posedge clk);
                #1 data_out_ready = 1'b1;
                @(negedge clk);
                check("simul_pre_count", 32'(count), 32'd8);
                @(negedge clk);
                check("simul_count", 32'(count), 32'd8);
            end
        join
        drain("simul_drain");

        check("total_ov", 32'(ov_seen), 32'd2);
        check("total_fe", 32'(fe_seen), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
